// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the serial sequence detector.
package seq_detect_pkg;

  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int LEN_W       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_shift_match.sv
// History shift register with a length-masked compare against the pattern.
module seq_shift_match #(
  parameter int PAT_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               shift,
  input  logic               x,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [2:0]         len,
  output logic               hit
);

  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_nxt;
  logic [PAT_MAX-1:0] mask_lo;
  logic [PAT_MAX-1:0] mask;

  // hit reflects the history as it will be after x is shifted in this cycle
  always_comb begin
    hist_nxt = {hist[PAT_MAX-2:0], x};
    mask_lo  = ~({PAT_MAX{1'b1}} << len);
    mask     = {mask_lo[PAT_MAX-2:0], 1'b1};
    hit      = ((hist_nxt ^ pattern) & mask) == '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence detector controller: config handshake, FSM and saturating match counter.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count
);

  state_t             state;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               idle_like;
  logic               start_acc;
  logic               sample;
  logic               hit;
  logic               counted;

  always_comb begin
    idle_like = (state == IDLE) || (state == DONE);
    start_acc = idle_like && start;
    sample    = !idle_like && !abort;
    // a match counts once the (len+1)-th bit has been sampled
    counted   = sample && hit && ((state == RUN) || (fill_q == len_q));
    cnt_inc   = (match_count == '1) ? match_count : match_count + 1'b1;
  end

  seq_shift_match #(.PAT_MAX(PAT_MAX)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_acc),
    .shift   (sample),
    .x       (x),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      tgt_q       <= '0;
      fill_q      <= '0;
      match_count <= '0;
      y           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      y <= counted;
      if (idle_like && cfg_valid) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        tgt_q <= cfg_target;
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= FILL;
            fill_q      <= '0;
            match_count <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            cfg_ready   <= 1'b0;
          end
        end
        FILL, RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else begin
            if ((state == FILL) && (fill_q != len_q)) begin
              fill_q <= fill_q + 1'b1;
            end else begin
              state <= RUN;
            end
            // reaching the target overrides the FILL/RUN transition above
            if (counted) begin
              match_count <= cnt_inc;
              if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                cfg_ready <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_MAX, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: width of match counter and target.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 x  input  1  serial data bit; sampled every clock in FILL/RUN.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  high in IDLE and DONE only; transfer when cfg_valid and cfg_ready at a rising edge.
REQ-008 cfg_pattern  input  PAT_MAX  pattern; bit 0 is the most recently received bit.
REQ-009 cfg_len  input  3  pattern length minus 1 (1..8 bits).
REQ-010 cfg_target  input  CNT_W  matches to finish; 0 = unlimited.
REQ-011 start  input  1  one-cycle pulse; begins detection.
REQ-012 abort  input  1  one-cycle pulse; stops detection.
REQ-013 y  output  1  one-cycle match pulse.
REQ-014 busy  output  1  high in FILL and RUN.
REQ-015 done  output  1  high in DONE.
REQ-016 match_count  output  CNT_W  matches since last start.

Function
REQ-017 FSM states IDLE, FILL, RUN, DONE; reset state IDLE.
REQ-018 IDLE/DONE: accepted config latched into pattern/len/target registers; start -> FILL, history cleared, fill counter and match_count cleared.
REQ-019 cfg transfer and start in same cycle: new config latched and used by that run.
REQ-020 FILL: x shifted into history (LSB side) each cycle; after len+1 bits sampled -> RUN; a match on the (len+1)-th bit counts.
REQ-021 RUN: x shifted each cycle; match = history[len:0] equals pattern[len:0]; bits above len ignored.
REQ-022 y high exactly the cycle after the edge that sampled the completing bit; one pulse per match.
REQ-023 Overlapping matches count; history not cleared on match (111 pattern on 1111 -> 2 matches).
REQ-024 match_count increments with each y, saturates at 2^CNT_W-1.
REQ-025 target non-zero and match_count reaches target -> DONE on the same edge the count updates.
REQ-026 DONE: done=1, busy=0, match_count held; stays until start (-> FILL) or reset; config transfer alone keeps DONE.
REQ-027 abort in FILL/RUN -> IDLE next edge; match_count held; abort ignored in IDLE/DONE.
REQ-028 abort coincident with completing bit: abort wins; no y, no increment.
REQ-029 start while busy ignored; cfg_valid while busy ignored (cfg_ready=0, registers unchanged).

Reset
REQ-030 reset low: state IDLE, history 0, pattern 0, len 0, target 0, match_count 0, y 0, busy 0, done 0, cfg_ready 1 (async assert, sync to clk on release).
REQ-031 reset mid-run discards history and count; no y after reset assertion.

Structure
REQ-032 Shared include seq_detect_pkg holds state encodings (IDLE=2'b00, FILL=2'b01, RUN=2'b10, DONE=2'b11), PAT_MAX, CNT_W defaults.
REQ-033 Sub-module seq_shift_match: history shift register plus length-masked compare; controller owns FSM, config, counter.

Verification
REQ-034 pattern 8'h07, len 2, target 0, start, x=1,1,1,1,0 -> y after 3rd and 4th bits, match_count=2, busy=1.
REQ-035 pattern 8'h16 (10110), len 4, target 2, x=1,0,1,1,0,1,0,1,1,0 -> y after bits 5 and 10, done=1, match_count=2, further x ignored.
REQ-036 cfg_valid with pattern 8'hFF during RUN -> cfg_ready=0, detection continues with old pattern.
REQ-037 abort on the completing bit of 8'h07 pattern -> no y, match_count unchanged, IDLE next cycle.
REQ-038 pattern 8'h01, len 0, target 0, x=1 for 300 cycles -> match_count saturates at 255, y every cycle.
REQ-039 reset low mid-RUN with match_count=5 -> all outputs reset values immediately, cfg_ready=1.
